proc_param_mem: RTL and testbench
=================================

Name: proc_param_mem

Overview:
- Parametrised next-generation multicycle processor core. Data width and register count are configurable.
- Adds load/store to an external memory over a req/ack handshake, a conditional move (mvnz) and an optional AND opcode.
- Instructions enter on DIN when Run is high. Sits beside the memory block and replaces the fixed 9-bit/8-register core.

Parameters:
- DW, 9, datapath and instruction width; must satisfy DW >= 3+2*RW.
- NREG, 8, number of general registers; power of two, 2..8.
- RW, $clog2(NREG), register-index field width (derived localparam).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  instruction-valid strobe, sampled only in IDLE.
- DIN  in  DW  instruction word; also the mvi immediate one cycle after the instruction is accepted.
- Done  out  1  one-cycle pulse in the final cycle of each instruction.
- BusWires  out  DW  internal bus value, for debug.
- RegsFlat  out  NREG*DW  register file; Rk occupies bits [k*DW +: DW].
- MemReq  out  1  memory request, held until MemAck.
- MemWr  out  1  1 = store, 0 = load; valid while MemReq.
- MemAddr  out  DW  address, equal to Ry while MemReq.
- MemWdata  out  DW  store data, equal to Rx while MemReq.
- MemRdata  in  DW  load data, valid in the MemAck cycle.
- MemAck  in  1  completes a request; ignored when MemReq=0.

Behaviour:
- Encoding: opcode = DIN[DW-1:DW-3]; X = next RW bits below the opcode; Y = next RW bits below X. Remaining low bits are ignored.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 ld, 101 st, 110 mvnz, 111 and.
- FSM states: IDLE, T1, T2, T3, MEM.
- In IDLE with Run=1: IR <= DIN, next state T1. With Run=0: stay in IDLE. Run is ignored in every other state.
- Register writes happen on the clock edge that ends the Done cycle.
- mv: in T1, Rx <= Ry; Done; go to IDLE.
- mvi: in T1, Rx <= DIN; Done; go to IDLE.
- mvnz: in T1, Rx <= Ry only if G != 0; Done either way; go to IDLE.
- add/sub/and: T1 A <= Rx; T2 G <= A op Ry; T3 Rx <= G, Done, go to IDLE. Latency is 3 cycles after accept.
- Arithmetic is modulo 2^DW with no carry out. sub computes A - Ry.
- G keeps its value between instructions; only add/sub/and write G.
- ld/st: T1 moves to MEM. In MEM, MemReq=1 with MemAddr, MemWr and MemWdata stable. The core stays in MEM until MemAck=1.
- On MemAck: Done; ld writes Rx <= MemRdata; go to IDLE.
- Minimum ld/st latency is 2 cycles, with MemAck in the first MEM cycle. There is no timeout.
- MemReq, MemWr, MemAddr and MemWdata are 0 outside MEM.
- BusWires carries the selected source each cycle and is 0 in IDLE.
- If X = Y, reads use the old register value.
- Reset: state IDLE; all Rk, A, G and IR = 0; Done = 0; MemReq = 0 in the cycle after Reset. Reset overrides everything, including mid-instruction and mid-MEM; any pending MemAck is dropped.

Optional Feature:
- Macro PROC_AND_OP_EN.
- Defined: opcode 111 performs bitwise AND, G <= A & Ry, with add timing.
- Undefined: opcode 111 is a nop. Done pulses in T1; no register, A or G changes.

Decomposition:
- Package proc_pkg: opcode localparams, FSM state enum, function for extracting X/Y fields.
- Sub-module proc_alu: combinational, parameter DW, with inputs A, B and op; outputs A+B, A-B, A&B.
- Register file and FSM stay in proc_param_mem.

Test Plan (DW=9, NREG=8):
- Reset; DIN=9'o100 (mvi R0) with Run, then DIN=5 -> Done in T1; R0=5; all other registers 0.
- mvi R1=3; add R0,R1 (9'o201) -> Done 3 cycles after accept, R0=8. sub R0,R1 -> R0=5. With R0=0, R1=1, sub -> R0=9'h1FF.
- sub R1,R1 (G=0); mvnz R2,R0 (9'o620) -> R2 unchanged. add R0,R1 (G!=0); mvnz R2,R0 -> R2=R0.
- st R0,[R1] (9'o501), R0=5, R1=3, MemAck after 3 cycles -> MemReq high 3 cycles, MemAddr=3, MemWdata=5, MemWr=1, Done with MemAck.
- ld R3,[R1] (9'o431) with MemRdata=9'h0A5 on MemAck -> R3=9'h0A5.
- Reset during T2 of add and during MEM -> next cycle IDLE, RegsFlat=0, Done=0, MemReq=0. Run held high while busy -> no extra accept.
- Opcode 111 (9'o701), R0=9'h0F3, R1=9'h03C -> with macro R0=9'h030; without macro Done in T1 and R0 unchanged.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the parametrised multicycle core: opcodes, FSM states
// and instruction field extraction.
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_AND  = 3'b111;

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_MEM} state_t;

  function automatic int ir_field(input logic [31:0] ir, input int lsb, input int rw);
    return int'((ir >> lsb) & ((32'd1 << rw) - 32'd1));
  endfunction

  // X sits directly below the 3-bit opcode, Y directly below X.
  function automatic int field_x(input logic [31:0] ir, input int dw, input int rw);
    return ir_field(ir, dw - 3 - rw, rw);
  endfunction

  function automatic int field_y(input logic [31:0] ir, input int dw, input int rw);
    return ir_field(ir, dw - 3 - 2 * rw, rw);
  endfunction

endpackage

// File: rtl/proc_param_mem_if.sv
// External memory req/ack bus between the core (master) and a memory (slave).
interface proc_param_mem_if #(parameter int DW = 9);
  logic          MemReq;
  logic          MemWr;
  logic [DW-1:0] MemAddr;
  logic [DW-1:0] MemWdata;
  logic [DW-1:0] MemRdata;
  logic          MemAck;

  modport master (output MemReq, MemWr, MemAddr, MemWdata, input MemRdata, MemAck);
  modport slave  (input MemReq, MemWr, MemAddr, MemWdata, output MemRdata, MemAck);
endinterface

// File: rtl/proc_alu.sv
// Combinational ALU producing sum, difference and bitwise AND in parallel.
module proc_alu #(
  parameter int DW = 9
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] sum,
  output logic [DW-1:0] diff,
  output logic [DW-1:0] conj
);
  assign sum  = a + b;
  assign diff = a - b;
  assign conj = a & b;
endmodule

// File: rtl/proc_param_mem.sv
// Parametrised multicycle core with register file, FSM and req/ack load/store.
// Define PROC_AND_OP_EN to make opcode 111 a bitwise AND; otherwise it is a nop.
module proc_param_mem
  import proc_pkg::*;
#(
  parameter int DW   = 9,
  parameter int NREG = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic [DW-1:0]        DIN,
  output logic                 Done,
  output logic [DW-1:0]        BusWires,
  output logic [NREG*DW-1:0]   RegsFlat,
  proc_param_mem_if.master     mem
);
  localparam int RW = $clog2(NREG);

  state_t        state, nstate;
  logic [DW-1:0] ir, a_q, g_q;
  logic [DW-1:0] regs [NREG];
  logic [2:0]    op;
  logic [RW-1:0] x_idx, y_idx;
  logic [DW-1:0] rx, ry;
  logic [DW-1:0] alu_sum, alu_diff, alu_and, g_d;
  logic          reg_we, a_we, g_we;
  logic [DW-1:0] reg_wd;

  assign op    = ir[DW-1 -: 3];
  assign x_idx = RW'(field_x(32'(ir), DW, RW));
  assign y_idx = RW'(field_y(32'(ir), DW, RW));
  assign rx    = regs[x_idx];
  assign ry    = regs[y_idx];

  proc_alu #(.DW(DW)) u_alu (
    .a    (a_q),
    .b    (ry),
    .sum  (alu_sum),
    .diff (alu_diff),
    .conj (alu_and)
  );

  always_comb begin
    case (op)
      OP_SUB:  g_d = alu_diff;
      OP_AND:  g_d = alu_and;
      default: g_d = alu_sum;
    endcase
  end

  always_comb begin
    nstate       = state;
    Done         = 1'b0;
    BusWires     = '0;
    reg_we       = 1'b0;
    reg_wd       = '0;
    a_we         = 1'b0;
    g_we         = 1'b0;
    mem.MemReq   = 1'b0;
    mem.MemWr    = 1'b0;
    mem.MemAddr  = '0;
    mem.MemWdata = '0;
    unique case (state)
      S_IDLE: if (Run) nstate = S_T1;
      S_T1: begin
        case (op)
          OP_MV: begin
            BusWires = ry; reg_we = 1'b1; reg_wd = ry; Done = 1'b1; nstate = S_IDLE;
          end
          OP_MVI: begin
            BusWires = DIN; reg_we = 1'b1; reg_wd = DIN; Done = 1'b1; nstate = S_IDLE;
          end
          OP_MVNZ: begin
            BusWires = ry; reg_we = (g_q != '0); reg_wd = ry; Done = 1'b1; nstate = S_IDLE;
          end
          OP_ADD, OP_SUB: begin
            BusWires = rx; a_we = 1'b1; nstate = S_T2;
          end
          OP_LD, OP_ST: begin
            BusWires = ry; nstate = S_MEM;
          end
`ifdef PROC_AND_OP_EN
          OP_AND: begin
            BusWires = rx; a_we = 1'b1; nstate = S_T2;
          end
`else
          OP_AND: begin
            Done = 1'b1; nstate = S_IDLE;
          end
`endif
          default: nstate = S_IDLE;
        endcase
      end
      S_T2: begin
        BusWires = ry; g_we = 1'b1; nstate = S_T3;
      end
      S_T3: begin
        BusWires = g_q; reg_we = 1'b1; reg_wd = g_q; Done = 1'b1; nstate = S_IDLE;
      end
      S_MEM: begin
        // Address and store data come straight from the register file, which
        // cannot change while the request is outstanding.
        mem.MemReq   = 1'b1;
        mem.MemWr    = (op == OP_ST);
        mem.MemAddr  = ry;
        mem.MemWdata = rx;
        BusWires     = ry;
        if (mem.MemAck) begin
          Done   = 1'b1;
          nstate = S_IDLE;
          if (op == OP_LD) begin
            BusWires = mem.MemRdata; reg_we = 1'b1; reg_wd = mem.MemRdata;
          end
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
      ir    <= '0;
      a_q   <= '0;
      g_q   <= '0;
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
    end else begin
      state <= nstate;
      if (state == S_IDLE && Run) ir <= DIN;
      if (a_we) a_q <= rx;
      if (g_we) g_q <= g_d;
      if (reg_we) regs[x_idx] <= reg_wd;
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_flat
    assign RegsFlat[k*DW +: DW] = regs[k];
  end

endmodule

// File: tb/tb_proc_param_mem.sv
// Self-checking bench for proc_param_mem: instruction table with a latency
// scoreboard plus hand-written reset and busy-Run sequences.
module tb_proc_param_mem;
  localparam int DW   = 9;
  localparam int NREG = 8;

  logic               Clock = 1'b0;
  logic               Reset;
  logic               Run;
  logic [DW-1:0]      DIN;
  logic               Done;
  logic [DW-1:0]      BusWires;
  logic [NREG*DW-1:0] RegsFlat;

  proc_param_mem_if #(.DW(DW)) mem_bus ();

  proc_param_mem #(.DW(DW), .NREG(NREG)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Run      (Run),
    .DIN      (DIN),
    .Done     (Done),
    .BusWires (BusWires),
    .RegsFlat (RegsFlat),
    .mem      (mem_bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic [8:0]  ins;
    logic [8:0]  imm;
    int          ack_dly;
    logic [8:0]  rdata;
    int          lat;
    int          r;
    logic [8:0]  val;
    int          req;
    logic [8:0]  addr;
    logic [8:0]  wdata;
    logic        wr;
  } vec_t;

  typedef struct {
    string name;
    int    lat;
  } exp_t;

  vec_t vt [20];
  exp_t sb [$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] getr(input int k);
    return RegsFlat[k*DW +: DW];
  endfunction

  task automatic exec(input vec_t v);
    int         lat;
    int         rc;
    bit         fin;
    logic [8:0] a_seen, w_seen;
    logic       wr_seen;
    exp_t       e;
    sb.push_back('{v.name, v.lat});
    a_seen = '0; w_seen = '0; wr_seen = 1'b0;
    @(negedge Clock);
    Run = 1'b1; DIN = v.ins; mem_bus.MemAck = 1'b0;
    @(negedge Clock);
    Run = 1'b0; DIN = v.imm;
    lat = 1; rc = 0; fin = 1'b0;
    while (!fin && lat <= 20) begin
      if (mem_bus.MemReq) begin
        rc++;
        a_seen = mem_bus.MemAddr; w_seen = mem_bus.MemWdata; wr_seen = mem_bus.MemWr;
        if (rc >= v.ack_dly) begin
          mem_bus.MemAck = 1'b1; mem_bus.MemRdata = v.rdata;
        end
      end
      #1;
      if (Done) fin = 1'b1;
      else begin
        @(negedge Clock);
        mem_bus.MemAck = 1'b0;
        lat++;
      end
    end
    if (!fin) check({v.name, " timeout"}, 1, 0);
    e = sb.pop_front();
    check({e.name, " latency"}, lat, e.lat);
    @(posedge Clock);
    #1;
    mem_bus.MemAck = 1'b0;
    check({v.name, " result"}, getr(v.r), v.val);
    check({v.name, " idle MemReq"}, mem_bus.MemReq, 0);
    if (v.req > 0) begin
      check({v.name, " req cycles"}, rc, v.req);
      check({v.name, " MemAddr"}, a_seen, v.addr);
      check({v.name, " MemWdata"}, w_seen, v.wdata);
      check({v.name, " MemWr"}, wr_seen, v.wr);
    end
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1; Run = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    vt[0]  = '{"mvi R0,5",    9'o100, 9'd5,   0, 9'd0,   1, 0, 9'd5,   0, 9'd0, 9'd0, 1'b0};
    vt[1]  = '{"mvi R1,3",    9'o110, 9'd3,   0, 9'd0,   1, 1, 9'd3,   0, 9'd0, 9'd0, 1'b0};
    vt[2]  = '{"add R0,R1",   9'o201, 9'd0,   0, 9'd0,   3, 0, 9'd8,   0, 9'd0, 9'd0, 1'b0};
    vt[3]  = '{"sub R0,R1",   9'o301, 9'd0,   0, 9'd0,   3, 0, 9'd5,   0, 9'd0, 9'd0, 1'b0};
    vt[4]  = '{"mvi R0,0",    9'o100, 9'd0,   0, 9'd0,   1, 0, 9'd0,   0, 9'd0, 9'd0, 1'b0};
    vt[5]  = '{"mvi R1,1",    9'o110, 9'd1,   0, 9'd0,   1, 1, 9'd1,   0, 9'd0, 9'd0, 1'b0};
    vt[6]  = '{"sub wrap",    9'o301, 9'd0,   0, 9'd0,   3, 0, 9'h1FF, 0, 9'd0, 9'd0, 1'b0};
    vt[7]  = '{"sub R1,R1",   9'o311, 9'd0,   0, 9'd0,   3, 1, 9'd0,   0, 9'd0, 9'd0, 1'b0};
    vt[8]  = '{"mvnz G=0",    9'o620, 9'd0,   0, 9'd0,   1, 2, 9'd0,   0, 9'd0, 9'd0, 1'b0};
    vt[9]  = '{"mvi R1,3b",   9'o110, 9'd3,   0, 9'd0,   1, 1, 9'd3,   0, 9'd0, 9'd0, 1'b0};
    vt[10] = '{"add wrap",    9'o201, 9'd0,   0, 9'd0,   3, 0, 9'd2,   0, 9'd0, 9'd0, 1'b0};
    vt[11] = '{"mvnz G!=0",   9'o620, 9'd0,   0, 9'd0,   1, 2, 9'd2,   0, 9'd0, 9'd0, 1'b0};
    vt[12] = '{"mvi R0,5b",   9'o100, 9'd5,   0, 9'd0,   1, 0, 9'd5,   0, 9'd0, 9'd0, 1'b0};
    vt[13] = '{"st R0,[R1]",  9'o501, 9'd0,   3, 9'h1EE, 4, 0, 9'd5,   3, 9'd3, 9'd5, 1'b1};
    vt[14] = '{"ld R3,[R1]",  9'o431, 9'd0,   1, 9'h0A5, 2, 3, 9'h0A5, 1, 9'd3, 9'd0, 1'b0};
    vt[15] = '{"mv R4,R2",    9'o042, 9'd0,   0, 9'd0,   1, 4, 9'd2,   0, 9'd0, 9'd0, 1'b0};
    vt[16] = '{"add R2,R2",   9'o222, 9'd0,   0, 9'd0,   3, 2, 9'd4,   0, 9'd0, 9'd0, 1'b0};
    vt[17] = '{"mvi R0,0F3",  9'o100, 9'h0F3, 0, 9'd0,   1, 0, 9'h0F3, 0, 9'd0, 9'd0, 1'b0};
    vt[18] = '{"mvi R1,03C",  9'o110, 9'h03C, 0, 9'd0,   1, 1, 9'h03C, 0, 9'd0, 9'd0, 1'b0};
`ifdef PROC_AND_OP_EN
    vt[19] = '{"op111 and",   9'o701, 9'd0,   0, 9'd0,   3, 0, 9'h030, 0, 9'd0, 9'd0, 1'b0};
`else
    vt[19] = '{"op111 nop",   9'o701, 9'd0,   0, 9'd0,   1, 0, 9'h0F3, 0, 9'd0, 9'd0, 1'b0};
`endif

    Reset = 1'b1; Run = 1'b0; DIN = '0;
    mem_bus.MemAck = 1'b0; mem_bus.MemRdata = '0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("reset regs", RegsFlat, 0);
    check("reset Done", Done, 0);
    check("reset MemReq", mem_bus.MemReq, 0);
    check("reset BusWires", BusWires, 0);

    for (int i = 0; i < 20; i++) exec(vt[i]);
    check("op111 keeps R1", getr(1), 9'h03C);

    // Run held high while busy: only the first instruction is accepted.
    do_reset();
    exec(vt[0]);
    exec(vt[1]);
    @(negedge Clock);
    Run = 1'b1; DIN = 9'o201;
    @(negedge Clock);
    DIN = 9'o160;
    for (int c = 1; c <= 3; c++) begin
      #1;
      check($sformatf("runheld Done c%0d", c), Done, (c == 3));
      if (c < 3) @(negedge Clock);
    end
    Run = 1'b0;
    @(posedge Clock);
    #1;
    check("runheld R0", getr(0), 9'd8);
    check("runheld R6", getr(6), 9'd0);

    // Reset during T2 of add.
    @(negedge Clock);
    Run = 1'b1; DIN = 9'o201;
    @(negedge Clock);
    @(negedge Clock);
    #1;
    check("T2 BusWires", BusWires, 9'd3);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0; Run = 1'b0;
    #1;
    check("rst T2 regs", RegsFlat, 0);
    check("rst T2 Done", Done, 0);
    check("rst T2 MemReq", mem_bus.MemReq, 0);
    check("rst T2 BusWires", BusWires, 0);

    // Reset during MEM with a simultaneous MemAck that must be dropped.
    exec(vt[1]);
    @(negedge Clock);
    Run = 1'b1; DIN = 9'o431;
    @(negedge Clock);
    Run = 1'b0;
    @(negedge Clock);
    #1;
    check("MEM MemReq", mem_bus.MemReq, 1);
    check("MEM MemAddr", mem_bus.MemAddr, 9'd3);
    @(negedge Clock);
    Reset = 1'b1; mem_bus.MemAck = 1'b1; mem_bus.MemRdata = 9'h155;
    @(negedge Clock);
    Reset = 1'b0; mem_bus.MemAck = 1'b0;
    #1;
    check("rst MEM regs", RegsFlat, 0);
    check("rst MEM Done", Done, 0);
    check("rst MEM MemReq", mem_bus.MemReq, 0);
    @(negedge Clock);
    #1;
    check("rst MEM stays idle", mem_bus.MemReq, 0);
    check("rst MEM R3", getr(3), 9'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule
